// File: rtl/dac_stream_scheduler.sv
// ---------------------------------------------------------------------------
// dac_stream_scheduler
//
// Paced multi-channel sample scheduler sitting between the DDS cores and the
// SPI DAC controller. DDS frames (one code per channel) are buffered in a
// small frame FIFO. A pacer produces one tick per frame period, and each tick
// pops one frame into a held-frame register. The held frame's channels are
// then handed to the DAC controller one at a time, in ascending channel
// order, over a valid/ready handshake. Ticks that find the FIFO empty count
// as underruns. Ticks that arrive while a frame is still being sent count as
// overruns.
//
// Optional build macro: DAC_SCHED_MIDSCALE_ON_UNDERRUN_EN
//   defined   - an underrun overwrites every held lane with midscale before
//               the frame is sent
//   undefined - an underrun repeats the last frame unchanged
//   The underrun counter behaves the same in both builds.
//
// Ports:
//   clk           system clock (single domain)
//   rst           synchronous active-high reset
//   enable        pacer run; low holds the pacer counter at 0
//   clear_stats   one-cycle pulse that zeroes both statistics counters
//   sample_in     frame; channel k at [k*CODE_WIDTH +: CODE_WIDTH]
//   sample_valid  frame offered by the DDS side
//   sample_ready  FIFO not full
//   dac_code      code presented to the SPI controller
//   dac_ch        channel index of dac_code
//   dac_valid     dac_code/dac_ch valid
//   dac_ready     SPI controller idle / accepts
//   frame_tick    one-cycle strobe per pacer tick
//   fifo_level    number of frames held in the FIFO
//   underrun_cnt  saturating count of ticks that found the FIFO empty
//   overrun_cnt   saturating count of ticks dropped while still sending
// ---------------------------------------------------------------------------
module dac_stream_scheduler #(
    parameter int NUM_CH     = 2,
    parameter int CODE_WIDTH = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int FS_HZ      = 1_041_100,
    parameter int F_CLK_SYS  = 100_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            clear_stats,
    input  logic [NUM_CH*CODE_WIDTH-1:0]    sample_in,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    output logic [CODE_WIDTH-1:0]           dac_code,
    output logic [$clog2(NUM_CH):0]         dac_ch,
    output logic                            dac_valid,
    input  logic                            dac_ready,
    output logic                            frame_tick,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     underrun_cnt,
    output logic [15:0]                     overrun_cnt
);

    localparam int PERIOD = F_CLK_SYS / FS_HZ;
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW     = $clog2(FIFO_DEPTH) + 1;
    localparam int CW     = $clog2(NUM_CH) + 1;
    localparam int FW     = NUM_CH * CODE_WIDTH;

    localparam logic [PW-1:0]         PERIOD_LAST = PW'(PERIOD - 1);
    localparam logic [LW-1:0]         LEVEL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0]         CH_LAST     = CW'(NUM_CH - 1);
    localparam logic [CODE_WIDTH-1:0] MIDSCALE    = {1'b1, {(CODE_WIDTH-1){1'b0}}};
    localparam logic [FW-1:0]         MID_FRAME   = {NUM_CH{MIDSCALE}};
    localparam logic [15:0]           CNT_MAX     = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [PW-1:0]   pacer_cnt;

    logic [FW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    logic [FW-1:0]   held_frame;
    logic [CW-1:0]   ch;
    logic            wait_first;

    logic            load_frame;
    logic            underrun_evt;
    logic            overrun_evt;
    logic            enter_wait;
    logic            advance_ch;

    // Pacer: counts 0..PERIOD-1 while enabled; the tick is registered so it
    // is high on the cycle the counter has just wrapped back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pacer_cnt  <= '0;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            pacer_cnt  <= '0;
            frame_tick <= 1'b0;
        end else if (pacer_cnt == PERIOD_LAST) begin
            pacer_cnt  <= '0;
            frame_tick <= 1'b1;
        end else begin
            pacer_cnt  <= pacer_cnt + 1'b1;
            frame_tick <= 1'b0;
        end
    end

    // Full/empty come from the registered count only, so a push into an
    // empty FIFO is not visible to a pop in the same cycle.
    assign fifo_full    = (count == LEVEL_FULL);
    assign fifo_empty   = (count == '0);
    assign push         = sample_valid && !fifo_full;
    assign sample_ready = !fifo_full;
    assign fifo_level   = count;

    // Frame FIFO pointers and occupancy; pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sample_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and event decode. WAIT ignores dac_ready for its first
    // cycle so the controller has time to drop ready after the handshake.
    always_comb begin
        next_state   = state;
        load_frame   = 1'b0;
        pop          = 1'b0;
        underrun_evt = 1'b0;
        overrun_evt  = 1'b0;
        enter_wait   = 1'b0;
        advance_ch   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    load_frame   = 1'b1;
                    pop          = !fifo_empty;
                    underrun_evt = fifo_empty;
                    next_state   = SEND;
                end
            end
            SEND: begin
                overrun_evt = frame_tick;
                if (dac_ready) begin
                    enter_wait = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                overrun_evt = frame_tick;
                if (!wait_first && dac_ready) begin
                    if (ch < CH_LAST) begin
                        advance_ch = 1'b1;
                        next_state = SEND;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Held frame, channel index and WAIT settling flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_frame <= MID_FRAME;
            ch         <= '0;
            wait_first <= 1'b0;
        end else begin
            wait_first <= enter_wait;
            if (load_frame) begin
                ch <= '0;
            end else if (advance_ch) begin
                ch <= ch + 1'b1;
            end
            if (pop) begin
                held_frame <= fifo_mem[rd_ptr];
            end
`ifdef DAC_SCHED_MIDSCALE_ON_UNDERRUN_EN
            else if (underrun_evt) begin
                held_frame <= MID_FRAME;
            end
`endif
        end
    end

    // Lane select for the channel currently being sent.
    always_comb begin
        dac_code = held_frame[CODE_WIDTH-1:0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CW'(k)) begin
                dac_code = held_frame[k*CODE_WIDTH +: CODE_WIDTH];
            end
        end
    end

    assign dac_valid = (state == SEND);
    assign dac_ch    = ch;

    // Saturating statistics; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
        end else begin
            if (clear_stats) begin
                underrun_cnt <= '0;
            end else if (underrun_evt && (underrun_cnt != CNT_MAX)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
            if (clear_stats) begin
                overrun_cnt <= '0;
            end else if (overrun_evt && (overrun_cnt != CNT_MAX)) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

endmodule
